axi4l2mem_bridge: RTL

Parametrised AXI4-Lite slave to native memory-bus master bridge. It sits between an AXI4-Lite core and the SoC native bus (valid/addr/wdata/wstrb/rdata/ready).
- Adds a table of top-byte address remap windows.
- Adds selectable read/write arbitration.
- Adds a bus-timeout that returns SLVERR instead of hanging the core.

---
 rtl/axi4l2mem_bridge.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axi4l2mem_bridge.sv
// AXI4-Lite slave to native memory-bus master bridge.
// Holds AW/W/AR in private registers, arbitrates read vs write, remaps the
// top address byte through a small window table and bounds every native
// access with an optional timeout that answers SLVERR.
module axi4l2mem_bridge #(
    parameter int                     ADDR_WIDTH  = 32,
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     REMAP_NUM   = 1,
    parameter logic [REMAP_NUM*8-1:0] REMAP_SRC   = 8'h30,
    parameter logic [REMAP_NUM*8-1:0] REMAP_DST   = 8'h00,
    parameter int                     ARB_MODE    = 0,
    parameter int                     TIMEOUT_CYC = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic                    mem_valid_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ready_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, WRESP, RRESP} state_t;

    state_t                  state_q, state_d;
    logic                    aw_held_q, w_held_q, ar_held_q;
    logic                    awready_q, wready_q, arready_q;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_W-1:0]       w_strb_q;
    logic                    is_wr_q;
    logic                    last_wr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [1:0]              resp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [ADDR_WIDTH-1:0]   raw_addr, remap_addr;
    logic                    grant_rd, grant_wr, done_ok, done_to, expire;
    logic                    b_hs, r_hs;

    assign b_hs   = (state_q == WRESP) && bready_i;
    assign r_hs   = (state_q == RRESP) && rready_i;
    assign expire = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Channel holding registers; a channel reopens only once its response is accepted.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            ar_held_q <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (awvalid_i && awready_q) begin
                aw_addr_q <= awaddr_i;
                aw_held_q <= 1'b1;
                awready_q <= 1'b0;
            end else if (b_hs) begin
                aw_held_q <= 1'b0;
                awready_q <= 1'b1;
            end else if (!aw_held_q) begin
                awready_q <= 1'b1;
            end

            if (wvalid_i && wready_q) begin
                w_data_q <= wdata_i;
                w_strb_q <= wstrb_i;
                w_held_q <= 1'b1;
                wready_q <= 1'b0;
            end else if (b_hs) begin
                w_held_q <= 1'b0;
                wready_q <= 1'b1;
            end else if (!w_held_q) begin
                wready_q <= 1'b1;
            end

            if (arvalid_i && arready_q) begin
                ar_addr_q <= araddr_i;
                ar_held_q <= 1'b1;
                arready_q <= 1'b0;
            end else if (r_hs) begin
                ar_held_q <= 1'b0;
                arready_q <= 1'b1;
            end else if (!ar_held_q) begin
                arready_q <= 1'b1;
            end
        end
    end

    // Top-byte remap; walking down the table lets the lowest matching window win.
    always_comb begin
        raw_addr   = is_wr_q ? aw_addr_q : ar_addr_q;
        remap_addr = raw_addr;
        for (int i = REMAP_NUM - 1; i >= 0; i--) begin
            if (raw_addr[ADDR_WIDTH-1 -: 8] == REMAP_SRC[i*8 +: 8])
                remap_addr[ADDR_WIDTH-1 -: 8] = REMAP_DST[i*8 +: 8];
        end
    end

    // Next-state: arbitration in IDLE, completion/timeout in ACCESS, response handshakes.
    always_comb begin
        state_d  = state_q;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        done_ok  = 1'b0;
        done_to  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ar_held_q && aw_held_q && w_held_q) begin
                    if (ARB_MODE == 0 || last_wr_q) grant_rd = 1'b1;
                    else                            grant_wr = 1'b1;
                end else if (ar_held_q) begin
                    grant_rd = 1'b1;
                end else if (aw_held_q && w_held_q) begin
                    grant_wr = 1'b1;
                end
                if (grant_rd)      state_d = ACCESS;
                else if (grant_wr) state_d = (w_strb_q == '0) ? WRESP : ACCESS;
            end
            ACCESS: begin
                // Ready in the expiry cycle still completes normally.
                if (mem_ready_i) done_ok = 1'b1;
                else if (expire) done_to = 1'b1;
                if (done_ok || done_to) state_d = is_wr_q ? WRESP : RRESP;
            end
            WRESP:   if (bready_i) state_d = IDLE;
            RRESP:   if (rready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, grant bookkeeping, timeout counter and captured response.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            last_wr_q <= 1'b1;
            cnt_q     <= '0;
            resp_q    <= 2'b00;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant_rd || grant_wr) begin
                is_wr_q   <= grant_wr;
                last_wr_q <= grant_wr;
                cnt_q     <= '0;
                resp_q    <= 2'b00;
            end
            if (state_q == ACCESS) begin
                if (done_ok) begin
                    resp_q <= 2'b00;
                    if (!is_wr_q) rdata_q <= mem_rdata_i;
                end else if (done_to) begin
                    resp_q  <= 2'b10;
                    rdata_q <= '0;
                end else if (TIMEOUT_CYC != 0) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign awready_o   = awready_q;
    assign wready_o    = wready_q;
    assign arready_o   = arready_q;
    assign mem_valid_o = (state_q == ACCESS);
    assign mem_addr_o  = mem_valid_o ? remap_addr : '0;
    assign mem_wdata_o = (mem_valid_o && is_wr_q) ? w_data_q : '0;
    assign mem_wstrb_o = (mem_valid_o && is_wr_q) ? w_strb_q : '0;
    assign bvalid_o    = (state_q == WRESP);
    assign bresp_o     = bvalid_o ? resp_q : 2'b00;
    assign rvalid_o    = (state_q == RRESP);
    assign rresp_o     = rvalid_o ? resp_q : 2'b00;
    assign rdata_o     = rdata_q;

endmodule
